vec_load_store_unit: RTL and testbench

//   Moves 512-bit vectors between a 32-bit word-addressed data memory and the 4-entry vector register_file.

---
 rtl/vec_load_store_unit.sv | 135 +++++++++++++
 tb/tb_vec_load_store_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_load_store_unit.sv
// Vector load/store unit: packs 16 memory words into a register_file vector (LOAD) or unpacks one (STORE).
// Optional range check on the command base address is enabled by defining VEC_LSU_BOUNDS_EN.
module vec_load_store_unit #(
    parameter int ADDR_W    = 10,
    parameter int WORD_W    = 32,
    parameter int VEC_W     = 512,
    parameter int MEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_is_store,
    input  logic [1:0]        cmd_reg,
    input  logic [ADDR_W-1:0] cmd_base,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [1:0]        rf_op_code,
    output logic [1:0]        rf_read_addr,
    output logic [1:0]        rf_write_addr,
    output logic [VEC_W-1:0]  rf_write_data,
    input  logic [VEC_W-1:0]  rf_read_data
);

    localparam int NUM_WORDS = VEC_W / WORD_W;
    localparam int CNT_W     = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W:0]  LAST_BASE = (ADDR_W+1)'(MEM_DEPTH - NUM_WORDS);

    typedef enum logic [3:0] {
        S_IDLE, S_LD_REQ, S_LD_WAIT, S_LD_WB, S_ST_RD, S_ST_CAP, S_ST_WR, S_DONE, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [VEC_W-1:0]    buf_q, buf_d;
    logic [1:0]          reg_q, reg_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    prev_idx;

    // Read data arrives one cycle after the strobe, so it belongs to the previous index.
    assign prev_idx = cnt_q - 1'b1;

`ifndef VEC_LSU_BOUNDS_EN
    logic unused_last_base;
    assign unused_last_base = ^LAST_BASE;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            reg_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            reg_q   <= reg_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        reg_d   = reg_q;
        base_d  = base_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    reg_d  = cmd_reg;
                    base_d = cmd_base;
                    cnt_d  = '0;
`ifdef VEC_LSU_BOUNDS_EN
                    if ({1'b0, cmd_base} > LAST_BASE) state_d = S_ERR;
                    else
`endif
                    state_d = cmd_is_store ? S_ST_RD : S_LD_REQ;
                end
            end
            S_LD_REQ: begin
                if (cnt_q != '0) buf_d[prev_idx*WORD_W +: WORD_W] = mem_rdata;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) state_d = S_LD_WAIT;
            end
            S_LD_WAIT: begin
                buf_d[prev_idx*WORD_W +: WORD_W] = mem_rdata;
                state_d = S_LD_WB;
            end
            S_LD_WB:  state_d = S_DONE;
            S_ST_RD:  state_d = S_ST_CAP;
            S_ST_CAP: begin
                buf_d   = rf_read_data;
                state_d = S_ST_WR;
            end
            S_ST_WR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = (state_q == S_IDLE);
        done          = (state_q == S_DONE);
`ifdef VEC_LSU_BOUNDS_EN
        err           = (state_q == S_ERR);
`else
        err           = 1'b0;
`endif
        mem_re        = (state_q == S_LD_REQ);
        mem_we        = (state_q == S_ST_WR);
        mem_addr      = '0;
        mem_wdata     = '0;
        if (mem_re || mem_we) mem_addr = base_q + ADDR_W'(cnt_q);
        if (mem_we) mem_wdata = buf_q[cnt_q*WORD_W +: WORD_W];
        // Register file idles in the non-destructive read op; write only during write-back.
        rf_op_code    = (state_q == S_LD_WB) ? 2'b00 : 2'b01;
        rf_read_addr  = reg_q;
        rf_write_addr = reg_q;
        rf_write_data = buf_q;
    end

endmodule

// File: tb/tb_vec_load_store_unit.sv
// Self-checking bench for vec_load_store_unit: memory and register_file models, reference model, random commands.
// Build with VEC_LSU_BOUNDS_EN defined to exercise the range check.
module tb_vec_load_store_unit;

    localparam int AW    = 10;
    localparam int WW    = 32;
    localparam int VW    = 512;
    localparam int NW    = 16;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_is_store;
    logic [1:0]    cmd_reg;
    logic [AW-1:0] cmd_base;
    logic          done, err;
    logic [AW-1:0] mem_addr;
    logic          mem_re, mem_we;
    logic [WW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    rf_op_code, rf_read_addr, rf_write_addr;
    logic [VW-1:0] rf_write_data, rf_read_data;

    always #5 clk = ~clk;

    vec_load_store_unit dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_store(cmd_is_store),
        .cmd_reg(cmd_reg), .cmd_base(cmd_base), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rf_op_code(rf_op_code), .rf_read_addr(rf_read_addr), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .rf_read_data(rf_read_data)
    );

    // Environment: memory and register file seen by the DUT
    logic [WW-1:0] mem [0:DEPTH-1];
    logic [VW-1:0] rf  [0:3];
    // Reference model
    logic [WW-1:0] exp_mem [0:DEPTH-1];
    logic [VW-1:0] exp_rf  [0:3];

    int   checks = 0, errors = 0;
    int   rf_wr_cnt = 0, we_cnt = 0, re_cnt = 0, overlap_cnt = 0, bad_op_cnt = 0, accept_cnt = 0;
    logic [1:0] last_waddr = 2'd0;
    logic sync_req, log_en;
    int   addr_log[$];

    always @(posedge clk) begin
        if (sync_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= exp_mem[i];
            for (int r = 0; r < 4; r++) rf[r] <= exp_rf[r];
        end else begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                we_cnt++;
            end
            if (mem_re) begin
                mem_rdata <= mem[mem_addr];
                re_cnt++;
                if (log_en) addr_log.push_back(int'(mem_addr));
            end
            if (rf_op_code == 2'b00) begin
                rf[rf_write_addr] <= rf_write_data;
                rf_wr_cnt++;
                last_waddr = rf_write_addr;
            end
            if (rf_op_code == 2'b01) rf_read_data <= rf[rf_read_addr];
        end
        if (mem_re && mem_we) overlap_cnt++;
        if (rf_op_code[1]) bad_op_cnt++;
        if (cmd_valid && cmd_ready) accept_cnt++;
    end

    task automatic check_eq(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_outs"},
                 {cmd_ready, done, err, mem_re, mem_we, mem_addr, mem_wdata, rf_op_code, rf_read_addr, rf_write_addr},
                 {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 2'b01, 2'd0, 2'd0});
        check_eq({tag, "_wdata"}, rf_write_data, '0);
    endtask

    task automatic sync_env();
        @(negedge clk);
        sync_req = 1'b1;
        @(negedge clk);
        sync_req = 1'b0;
    endtask

    task automatic wait_ready();
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic model_cmd(input logic st, input logic [1:0] r, input int b);
        int a;
        for (int i = 0; i < NW; i++) begin
            a = (b + i) % DEPTH;
            if (st) exp_mem[a] = exp_rf[r][i*WW +: WW];
            else    exp_rf[r][i*WW +: WW] = exp_mem[a];
        end
    endtask

    task automatic run(input string tag, input logic st, input logic [1:0] r, input int b);
        int   lat;
        logic got_err, exp_err;
        lat = -1; got_err = 1'b0; exp_err = 1'b0;
`ifdef VEC_LSU_BOUNDS_EN
        exp_err = (b > DEPTH - NW);
`endif
        wait_ready();
        cmd_valid = 1'b1; cmd_is_store = st; cmd_reg = r; cmd_base = AW'(b);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done || err) begin
                lat = n;
                got_err = err;
                break;
            end
        end
        if (!exp_err) model_cmd(st, r, b);
        check_eq({tag, "_lat"}, lat, exp_err ? 1 : 19);
        check_eq({tag, "_err"}, got_err, exp_err);
        @(negedge clk);
        check_eq({tag, "_pulse"}, {done, err}, 2'b00);
        check_eq({tag, "_rf"}, rf[r], exp_rf[r]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, w0, a0, busy, lat;
        logic [VW-1:0] v;
        rst = 1'b0; cmd_valid = 1'b0; cmd_is_store = 1'b0; cmd_reg = '0; cmd_base = '0;
        sync_req = 1'b0; log_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = $urandom;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < NW; i++) exp_rf[r][i*WW +: WW] = $urandom;
        sync_env();
        @(negedge clk);
        check_reset_outs("rst0");
        rst = 1'b1;

        // Reset in the middle of a load
        wait_ready();
        c0 = rf_wr_cnt;
        cmd_valid = 1'b1; cmd_is_store = 1'b0; cmd_reg = 2'd0; cmd_base = 10'd300;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("t1_busy", mem_re, 1'b1);
        rst = 1'b0;
        #1 check_reset_outs("t1a");
        @(negedge clk);
        check_reset_outs("t1b");
        rst = 1'b1;
        check_eq("t1_rf_wr", rf_wr_cnt - c0, 0);
        check_eq("t1_rf0", rf[0], exp_rf[0]);

        // Load of a known pattern
        for (int i = 0; i < NW; i++) exp_mem[100+i] = WW'(i + 1);
        sync_env();
        c0 = rf_wr_cnt;
        run("t2", 1'b0, 2'd2, 100);
        check_eq("t2_rf_wr", rf_wr_cnt - c0, 1);
        check_eq("t2_waddr", last_waddr, 2'd2);
        for (int i = 0; i < NW; i++) v[i*WW +: WW] = WW'(i + 1);
        check_eq("t2_vec", rf[2], v);

        // Store it back elsewhere
        w0 = we_cnt;
        run("t3", 1'b1, 2'd2, 200);
        check_eq("t3_we_cycles", we_cnt - w0, 16);
        for (int i = 0; i < NW; i++) check_eq("t3_mem", mem[200+i], WW'(i + 1));

        // cmd_valid held across two loads
        wait_ready();
        a0 = accept_cnt; busy = 0;
        cmd_valid = 1'b1; cmd_is_store = 1'b0; cmd_reg = 2'd1; cmd_base = 10'd40;
        @(posedge clk);
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk);
            if (cmd_ready) busy++;
            if (n == 19) check_eq("t4_done1", done, 1'b1);
        end
        check_eq("t4_busy_ready", busy, 0);
        @(negedge clk);
        check_eq("t4_ready_idle", cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check_eq("t4_accepts", accept_cnt - a0, 2);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
        check_eq("t4_lat2", lat, 19);
        model_cmd(1'b0, 2'd1, 40);
        model_cmd(1'b0, 2'd1, 40);
        check_eq("t4_rf1", rf[1], exp_rf[1]);

        // Base near the top of memory
        addr_log.delete();
        c0 = rf_wr_cnt; w0 = re_cnt;
        log_en = 1'b1;
        run("t5", 1'b0, 2'd1, 1020);
        log_en = 1'b0;
`ifdef VEC_LSU_BOUNDS_EN
        check_eq("t5_no_re", re_cnt - w0, 0);
        check_eq("t5_no_rfw", rf_wr_cnt - c0, 0);
`else
        check_eq("t5_nreads", addr_log.size(), 16);
        for (int i = 0; i < NW && i < addr_log.size(); i++)
            check_eq("t5_addr", addr_log[i], (1020 + i) % DEPTH);
`endif

        // Store of a small scalar-valued vector
        exp_rf[3] = 512'd123456;
        sync_env();
        run("t6", 1'b1, 2'd3, 500);
        check_eq("t6_w0", mem[500], 32'd123456);
        for (int i = 1; i < NW; i++) check_eq("t6_wz", mem[500+i], 32'd0);

        // Random commands against the reference model
        for (int k = 0; k < 24; k++)
            run("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), int'($urandom_range(0, DEPTH-1)));

        for (int r = 0; r < 4; r++) check_eq("end_rf", rf[r], exp_rf[r]);
        for (int i = 0; i < DEPTH; i++) check_eq("end_mem", mem[i], exp_mem[i]);
        check_eq("re_we_excl", overlap_cnt, 0);
        check_eq("rf_op_legal", bad_op_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
